raster_scan_ctrl: RTL and testbench

//  Sequencer between the triangle setup stage and the per-pixel coverage/shading datapath.
//  - Accepts one triangle (3 vertices, fixed point) per valid/ready handshake.
//  - Reduces the vertices to a rounded, screen-clamped bounding box.
//  - Walks every pixel in that box in row-major order, one sample per handshake.
//  - Replaces the free-running-counter sampling of the bounding box with proper flow control.

---
 rtl/raster_scan_ctrl_pkg.sv | 15 +
 rtl/raster_scan_ctrl_bbox_reduce.sv | 38 +++
 rtl/raster_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_raster_scan_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_scan_ctrl_pkg.sv
// Shared constants and state encoding for the raster scan sequencer.
package raster_scan_ctrl_pkg;
   localparam int DEF_COORD_W  = 16;
   localparam int DEF_FRAC_W   = 6;
   localparam int DEF_SCREEN_W = 320;
   localparam int DEF_SCREEN_H = 240;
   localparam int PIX_W        = 10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BOX  = 2'd1,
      S_SCAN = 2'd2,
      S_DONE = 2'd3
   } state_t;
endpackage

// File: rtl/raster_scan_ctrl_bbox_reduce.sv
// One axis of the bounding box: 3-input min/max, round to nearest pixel, clamp to screen.
module bbox_reduce #(
   parameter int COORD_W = 16,
   parameter int FRAC_W  = 6,
   parameter int PIX_W   = 10,
   parameter int LIMIT   = 320
) (
   input  logic [COORD_W-1:0] a,
   input  logic [COORD_W-1:0] b,
   input  logic [COORD_W-1:0] c,
   output logic [PIX_W-1:0]   lo,
   output logic [PIX_W-1:0]   hi,
   output logic               empty
);
   // Rounded values keep one extra bit so 0xFFFF rounds to 1024 instead of wrapping.
   localparam int RW = COORD_W + 1 - FRAC_W;
   localparam logic [RW-1:0]      MAX_PIX = RW'(LIMIT - 1);
   localparam logic [COORD_W:0]   HALF    = (COORD_W+1)'(1 << (FRAC_W - 1));

   logic [COORD_W-1:0] mn;
   logic [COORD_W-1:0] mx;
   logic [RW-1:0]      mn_r;
   logic [RW-1:0]      mx_r;

   always_comb begin
      mn = a;
      mx = a;
      if (b < mn) mn = b;
      if (c < mn) mn = c;
      if (b > mx) mx = b;
      if (c > mx) mx = c;
      mn_r  = RW'(({1'b0, mn} + HALF) >> FRAC_W);
      mx_r  = RW'(({1'b0, mx} + HALF) >> FRAC_W);
      empty = (mn_r > MAX_PIX);
      lo    = mn_r[PIX_W-1:0];
      hi    = (mx_r > MAX_PIX) ? MAX_PIX[PIX_W-1:0] : mx_r[PIX_W-1:0];
   end
endmodule

// File: rtl/raster_scan_ctrl.sv
// Triangle-to-pixel sequencer: latches a triangle, reduces it to a clamped bounding box
// and emits every pixel of that box in row-major order under valid/ready flow control.
//
// state  | meaning
// IDLE   | waiting for a triangle, tri_ready high
// BOX    | vertices latched, bounds computed and registered
// SCAN   | presenting cur_x/cur_y as a sample, advance on handshake
// DONE   | one-cycle tri_done pulse
module raster_scan_ctrl
   import raster_scan_ctrl_pkg::*;
#(
   parameter int COORD_W  = DEF_COORD_W,
   parameter int FRAC_W   = DEF_FRAC_W,
   parameter int SCREEN_W = DEF_SCREEN_W,
   parameter int SCREEN_H = DEF_SCREEN_H
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               tri_valid,
   output logic               tri_ready,
   input  logic [COORD_W-1:0] v0x,
   input  logic [COORD_W-1:0] v1x,
   input  logic [COORD_W-1:0] v2x,
   input  logic [COORD_W-1:0] v0y,
   input  logic [COORD_W-1:0] v1y,
   input  logic [COORD_W-1:0] v2y,
   output logic               smp_valid,
   input  logic               smp_ready,
   output logic [COORD_W-1:0] smp_x,
   output logic [COORD_W-1:0] smp_y,
   output logic               smp_last,
   output logic               tri_done,
   output logic               busy
);
   state_t state_q, state_d;
   logic [COORD_W-1:0] v0x_q, v1x_q, v2x_q, v0y_q, v1y_q, v2y_q;
   logic [COORD_W-1:0] v0x_d, v1x_d, v2x_d, v0y_d, v1y_d, v2y_d;
   logic [PIX_W-1:0]   xmin_q, xmax_q, ymin_q, ymax_q;
   logic [PIX_W-1:0]   xmin_d, xmax_d, ymin_d, ymax_d;
   logic [PIX_W-1:0]   cur_x_q, cur_y_q, cur_x_d, cur_y_d;
   logic [PIX_W-1:0]   bx_lo, bx_hi, by_lo, by_hi;
   logic               bx_empty, by_empty;
   logic               at_last;

   bbox_reduce #(.COORD_W(COORD_W), .FRAC_W(FRAC_W), .PIX_W(PIX_W), .LIMIT(SCREEN_W)) u_bbox_x (
      .a(v0x_q), .b(v1x_q), .c(v2x_q), .lo(bx_lo), .hi(bx_hi), .empty(bx_empty)
   );

   bbox_reduce #(.COORD_W(COORD_W), .FRAC_W(FRAC_W), .PIX_W(PIX_W), .LIMIT(SCREEN_H)) u_bbox_y (
      .a(v0y_q), .b(v1y_q), .c(v2y_q), .lo(by_lo), .hi(by_hi), .empty(by_empty)
   );

   assign at_last = (cur_x_q == xmax_q) && (cur_y_q == ymax_q);

   always_comb begin
      state_d = state_q;
      v0x_d   = v0x_q;
      v1x_d   = v1x_q;
      v2x_d   = v2x_q;
      v0y_d   = v0y_q;
      v1y_d   = v1y_q;
      v2y_d   = v2y_q;
      xmin_d  = xmin_q;
      xmax_d  = xmax_q;
      ymin_d  = ymin_q;
      ymax_d  = ymax_q;
      cur_x_d = cur_x_q;
      cur_y_d = cur_y_q;
      case (state_q)
         S_IDLE: begin
            if (tri_valid) begin
               v0x_d   = v0x;
               v1x_d   = v1x;
               v2x_d   = v2x;
               v0y_d   = v0y;
               v1y_d   = v1y;
               v2y_d   = v2y;
               state_d = S_BOX;
            end
         end
         S_BOX: begin
            xmin_d = bx_lo;
            xmax_d = bx_hi;
            ymin_d = by_lo;
            ymax_d = by_hi;
            if (bx_empty || by_empty) begin
               state_d = S_DONE;
            end else begin
               cur_x_d = bx_lo;
               cur_y_d = by_lo;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (smp_ready) begin
               if (at_last) begin
                  state_d = S_DONE;
               end else if (cur_x_q == xmax_q) begin
                  cur_x_d = xmin_q;
                  cur_y_d = cur_y_q + PIX_W'(1);
               end else begin
                  cur_x_d = cur_x_q + PIX_W'(1);
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         v0x_q   <= '0;
         v1x_q   <= '0;
         v2x_q   <= '0;
         v0y_q   <= '0;
         v1y_q   <= '0;
         v2y_q   <= '0;
         xmin_q  <= '0;
         xmax_q  <= '0;
         ymin_q  <= '0;
         ymax_q  <= '0;
         cur_x_q <= '0;
         cur_y_q <= '0;
      end else begin
         state_q <= state_d;
         v0x_q   <= v0x_d;
         v1x_q   <= v1x_d;
         v2x_q   <= v2x_d;
         v0y_q   <= v0y_d;
         v1y_q   <= v1y_d;
         v2y_q   <= v2y_d;
         xmin_q  <= xmin_d;
         xmax_q  <= xmax_d;
         ymin_q  <= ymin_d;
         ymax_q  <= ymax_d;
         cur_x_q <= cur_x_d;
         cur_y_q <= cur_y_d;
      end
   end

   // Sample outputs come straight from flops, so they are stable while stalled.
   assign tri_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign smp_valid = (state_q == S_SCAN);
   assign smp_last  = (state_q == S_SCAN) && at_last;
   assign tri_done  = (state_q == S_DONE);
   assign smp_x     = COORD_W'({cur_x_q, {FRAC_W{1'b0}}});
   assign smp_y     = COORD_W'({cur_y_q, {FRAC_W{1'b0}}});
endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Self-checking bench for raster_scan_ctrl: bounding-box model plus directed triangles.
module tb_raster_scan_ctrl;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        tri_valid = 1'b0;
   logic        tri_ready;
   logic [15:0] v0x = '0, v1x = '0, v2x = '0, v0y = '0, v1y = '0, v2y = '0;
   logic        smp_valid;
   logic        smp_ready = 1'b1;
   logic [15:0] smp_x, smp_y;
   logic        smp_last, tri_done, busy;

   raster_scan_ctrl dut (
      .CLK(CLK), .RST(RST), .tri_valid(tri_valid), .tri_ready(tri_ready),
      .v0x(v0x), .v1x(v1x), .v2x(v2x), .v0y(v0y), .v1y(v1y), .v2y(v2y),
      .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_x(smp_x), .smp_y(smp_y),
      .smp_last(smp_last), .tri_done(tri_done), .busy(busy)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: expected sample stream derived from the bounding-box rules.
   int ex_x[$], ex_y[$], ex_l[$];
   int obs_x[$], obs_y[$], obs_l[$], obs_c[$];
   int exp_done_cyc = -1;
   int n_done = 0, last_done_cyc = -1, n_acc = 0, last_acc_cyc = -1, hs_count = 0;
   bit in_flight = 0, done_prev = 0, hold_prev = 0;
   int px = 0, py = 0, pl = 0;

   function automatic int rnd(input int u);
      return (u + 32) / 64;
   endfunction

   task automatic model_tri(input int ax, input int bx, input int cx,
                            input int ay, input int by, input int cy, input int t);
      int x0, x1, y0, y1;
      x0 = rnd((ax < bx) ? ((ax < cx) ? ax : cx) : ((bx < cx) ? bx : cx));
      x1 = rnd((ax > bx) ? ((ax > cx) ? ax : cx) : ((bx > cx) ? bx : cx));
      y0 = rnd((ay < by) ? ((ay < cy) ? ay : cy) : ((by < cy) ? by : cy));
      y1 = rnd((ay > by) ? ((ay > cy) ? ay : cy) : ((by > cy) ? by : cy));
      if (x1 > 319) x1 = 319;
      if (y1 > 239) y1 = 239;
      if (x0 > 319 || y0 > 239) begin
         exp_done_cyc = t + 2;
      end else begin
         for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) begin
               ex_x.push_back(x * 64);
               ex_y.push_back(y * 64);
               ex_l.push_back((x == x1 && y == y1) ? 1 : 0);
            end
      end
   endtask

   always @(negedge CLK) begin
      if (RST) begin
         ex_x.delete(); ex_y.delete(); ex_l.delete();
         in_flight = 0; done_prev = 0; hold_prev = 0; exp_done_cyc = -1;
      end else begin
         chk("busy_is_not_ready", busy, !tri_ready);
         if (in_flight) chk("ready_low_while_busy", tri_ready, 0);
         if (done_prev) chk("ready_after_done", tri_ready, 1);
         chk("tri_done_timing", tri_done, (cyc == exp_done_cyc) ? 1 : 0);
         if (tri_done) begin
            chk("drained_at_done", ex_x.size(), 0);
            n_done++;
            last_done_cyc = cyc;
            in_flight = 0;
         end
         done_prev = tri_done;
         if (hold_prev) begin
            chk("stall_valid", smp_valid, 1);
            chk("stall_x", smp_x, px);
            chk("stall_y", smp_y, py);
            chk("stall_last", smp_last, pl);
         end
         if (smp_valid) begin
            if (ex_x.size() == 0) begin
               chk("unexpected_sample", smp_valid, 0);
            end else begin
               chk("smp_x", smp_x, ex_x[0]);
               chk("smp_y", smp_y, ex_y[0]);
               chk("smp_last", smp_last, ex_l[0]);
               if (smp_ready) begin
                  obs_x.push_back(smp_x);
                  obs_y.push_back(smp_y);
                  obs_l.push_back(smp_last);
                  obs_c.push_back(cyc);
                  hs_count++;
                  if (ex_l[0] == 1) exp_done_cyc = cyc + 1;
                  void'(ex_x.pop_front()); void'(ex_y.pop_front()); void'(ex_l.pop_front());
               end
            end
         end
         hold_prev = smp_valid && !smp_ready;
         px = smp_x; py = smp_y; pl = smp_last;
         if (tri_valid && tri_ready) begin
            model_tri(v0x, v1x, v2x, v0y, v1y, v2y, cyc);
            in_flight = 1;
            n_acc++;
            last_acc_cyc = cyc;
         end
      end
   end

   task automatic set_verts(input int ax, input int ay, input int bx, input int by,
                            input int cx, input int cy);
      v0x = 16'(ax); v0y = 16'(ay); v1x = 16'(bx); v1y = 16'(by); v2x = 16'(cx); v2y = 16'(cy);
   endtask

   task automatic send_tri(input bit keep, output int t);
      int w = 0;
      tri_valid = 1'b1;
      do begin
         @(negedge CLK);
         w++;
      end while (!tri_ready && w < 100);
      if (!tri_ready) chk("accept_timeout", tri_ready, 1);
      t = cyc;
      @(posedge CLK);
      #1;
      if (!keep) tri_valid = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int w = 0;
      while (n_done < target && w < 300) begin
         @(posedge CLK);
         #1;
         w++;
      end
      if (n_done < target) chk("done_timeout", n_done, target);
   endtask

   task automatic wait_hs(input int target);
      int w = 0;
      while (hs_count < target && w < 100) begin
         @(posedge CLK);
         #1;
         w++;
      end
      if (hs_count < target) chk("handshake_timeout", hs_count, target);
   endtask

   task automatic chk_sample(input int idx, input int x, input int y, input int l);
      if (idx < obs_x.size()) begin
         chk("log_x", obs_x[idx], x);
         chk("log_y", obs_y[idx], y);
         chk("log_last", obs_l[idx], l);
      end else begin
         chk("log_missing", obs_x.size(), idx + 1);
      end
   endtask

   task automatic chk_case1_log(input int ob);
      chk("case1_count", obs_x.size() - ob, 6);
      chk_sample(ob + 0, 'h40, 'h40, 0);
      chk_sample(ob + 1, 'h80, 'h40, 0);
      chk_sample(ob + 2, 'hC0, 'h40, 0);
      chk_sample(ob + 3, 'h40, 'h80, 0);
      chk_sample(ob + 4, 'h80, 'h80, 0);
      chk_sample(ob + 5, 'hC0, 'h80, 1);
   endtask

   initial begin
      int t, ta, nd, ob, hb, a0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_smp_valid", smp_valid, 0);
      chk("rst_smp_last", smp_last, 0);
      chk("rst_tri_done", tri_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_smp_x", smp_x, 0);
      chk("rst_smp_y", smp_y, 0);
      chk("rst_tri_ready", tri_ready, 1);
      @(posedge CLK);
      #1 RST = 1'b0;

      // basic 3x2 box
      nd = n_done; ob = obs_x.size();
      set_verts('h40, 'h40, 'hC0, 'h40, 'h40, 'h80);
      send_tri(0, t);
      chk("case1_model_len", ex_x.size(), 6);
      wait_done(nd + 1);
      chk_case1_log(ob);
      if (obs_c.size() > ob) chk("case1_first_cycle", obs_c[ob], t + 2);
      chk("case1_done_cycle", last_done_cyc, t + 8);

      // rounding up from 1.5 px
      nd = n_done; ob = obs_x.size();
      set_verts('h60, 'h40, 'h60, 'h40, 'h60, 'h40);
      send_tri(0, t);
      wait_done(nd + 1);
      chk("round_up_count", obs_x.size() - ob, 1);
      chk_sample(ob, 'h80, 'h40, 1);
      chk("round_up_done_cycle", last_done_cyc, t + 3);

      // degenerate triangle, x rounds down and y rounds up
      nd = n_done; ob = obs_x.size();
      set_verts('h5F, 'h60, 'h5F, 'h60, 'h5F, 'h60);
      send_tri(0, t);
      wait_done(nd + 1);
      chk("degenerate_count", obs_x.size() - ob, 1);
      chk_sample(ob, 'h40, 'h80, 1);

      // clamp to right and bottom screen edges; 0xFFFF must not wrap
      nd = n_done; ob = obs_x.size();
      set_verts('h4FC0, 'h3BC0, 'hFFFF, 'hFFFF, 'h4FC0, 'h3BC0);
      send_tri(0, t);
      wait_done(nd + 1);
      chk("clamp_count", obs_x.size() - ob, 1);
      chk_sample(ob, 'h4FC0, 'h3BC0, 1);

      // fully off-screen box
      nd = n_done; ob = obs_x.size();
      set_verts('h5000, 'h40, 'h6000, 'h40, 'hFFFF, 'h80);
      send_tri(0, t);
      wait_done(nd + 1);
      chk("empty_count", obs_x.size() - ob, 0);
      chk("empty_done_cycle", last_done_cyc, t + 2);

      // backpressure on the third sample
      nd = n_done; ob = obs_x.size(); hb = hs_count;
      set_verts('h40, 'h40, 'hC0, 'h40, 'h40, 'h80);
      send_tri(0, t);
      wait_hs(hb + 2);
      smp_ready = 1'b0;
      repeat (5) @(posedge CLK);
      #1 smp_ready = 1'b1;
      wait_done(nd + 1);
      chk_case1_log(ob);
      chk("stall_done_cycle", last_done_cyc, t + 13);

      // reset in the middle of a scan
      hb = hs_count;
      set_verts('h40, 'h40, 'hC0, 'h40, 'h40, 'h80);
      send_tri(0, t);
      wait_hs(hb + 2);
      RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      chk("midrst_smp_valid", smp_valid, 0);
      chk("midrst_tri_done", tri_done, 0);
      chk("midrst_tri_ready", tri_ready, 1);
      @(posedge CLK);
      #1;
      nd = n_done; ob = obs_x.size();
      set_verts('h80, 'h80, 'hC0, 'h80, 'h80, 'hC0);
      send_tri(0, t);
      wait_done(nd + 1);
      chk("after_rst_count", obs_x.size() - ob, 4);
      chk_sample(ob + 0, 'h80, 'h80, 0);
      chk_sample(ob + 1, 'hC0, 'h80, 0);
      chk_sample(ob + 2, 'h80, 'hC0, 0);
      chk_sample(ob + 3, 'hC0, 'hC0, 1);
      chk("after_rst_done_cycle", last_done_cyc, t + 6);

      // tri_valid held high across two triangles
      nd = n_done; a0 = n_acc;
      set_verts('h40, 'h40, 'h40, 'h40, 'h40, 'h40);
      send_tri(1, ta);
      ob = obs_x.size() + 1;
      set_verts('h80, 'h80, 'hC0, 'h80, 'h80, 'hC0);
      begin
         int w = 0;
         while (n_acc < a0 + 2 && w < 100) begin
            @(posedge CLK);
            #1;
            w++;
         end
      end
      tri_valid = 1'b0;
      chk("held_accept_count", n_acc, a0 + 2);
      chk("held_second_accept_cycle", last_acc_cyc, ta + 4);
      wait_done(nd + 2);
      chk_sample(ob - 1, 'h40, 'h40, 1);
      chk_sample(ob + 0, 'h80, 'h80, 0);
      chk_sample(ob + 3, 'hC0, 'hC0, 1);

      repeat (3) @(posedge CLK);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end
endmodule
